// File: rtl/vga_ram_painter.sv
// -----------------------------------------------------------------------------
// vga_ram_painter
//
// Paints solid rectangles (or the whole frame) into a video RAM through its
// write port, one pixel per clock in raster order. After every reset the
// whole frame is first cleared to black before any command is taken.
//
// Parameters
//   MAX_COL      last writable pixel column
//   MAX_ROW      last writable pixel row
//
// Ports
//   Clock        clock shared with the video RAM write port
//   Reset        asynchronous, active-high reset
//   iCmdValid    command request
//   oCmdReady    high while a command can be accepted
//   iOp          0 = fill rectangle (iX0/iX1, iY0/iY1), 1 = fill whole frame
//   iX0, iX1     rectangle corner columns (any order, clamped to MAX_COL)
//   iY0, iY1     rectangle corner rows (any order, clamped to MAX_ROW)
//   iColor       RGB value to paint
//   oWriteEnable RAM write strobe
//   oWriteCol    RAM write column
//   oWriteRow    RAM write row
//   oRGB         RAM write data
//   oDone        one-cycle pulse when a clear or fill has completed
//
// Timing: a command accepted on edge k produces writes visible after edges
// k+1 .. k+W*H, the oDone pulse after edge k+W*H+1, and oCmdReady returns one
// cycle after the oDone pulse. The write address/data outputs hold their last
// values whenever oWriteEnable is low.
// -----------------------------------------------------------------------------
module vga_ram_painter #(
  parameter int MAX_COL = 639,
  parameter int MAX_ROW = 479
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iOp,
  input  logic [10:0] iX0,
  input  logic [10:0] iX1,
  input  logic [9:0]  iY0,
  input  logic [9:0]  iY1,
  input  logic [2:0]  iColor,
  output logic        oWriteEnable,
  output logic [10:0] oWriteCol,
  output logic [9:0]  oWriteRow,
  output logic [2:0]  oRGB,
  output logic        oDone
);

  localparam logic [10:0] LP_MAX_COL = 11'(MAX_COL);
  localparam logic [9:0]  LP_MAX_ROW = 10'(MAX_ROW);

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    FILL       = 2'd2,
    DONE       = 2'd3
  } state_t;

  // Clamp a requested column onto the last writable column.
  function automatic logic [10:0] clamp_col(input logic [10:0] v);
    return (v > LP_MAX_COL) ? LP_MAX_COL : v;
  endfunction

  // Clamp a requested row onto the last writable row.
  function automatic logic [9:0] clamp_row(input logic [9:0] v);
    return (v > LP_MAX_ROW) ? LP_MAX_ROW : v;
  endfunction

  // FSM state and pixel walk counters
  state_t      r_state;
  logic [10:0] r_col;
  logic [9:0]  r_row;
  logic [10:0] r_xmin;
  logic [10:0] r_xmax;
  logic [9:0]  r_ymin;
  logic [9:0]  r_ymax;
  logic [2:0]  r_color;

  // Registered outputs
  logic        r_we;
  logic [10:0] r_wcol;
  logic [9:0]  r_wrow;
  logic [2:0]  r_rgb;
  logic        r_done;
  logic        r_ready;

  // Normalised bounds of the command currently on the inputs
  logic [10:0] w_x0c;
  logic [10:0] w_x1c;
  logic [9:0]  w_y0c;
  logic [9:0]  w_y1c;
  logic [10:0] w_xmin;
  logic [10:0] w_xmax;
  logic [9:0]  w_ymin;
  logic [9:0]  w_ymax;
  logic        w_last_col;
  logic        w_last_row;

  // Clamp first, then order each corner pair, so even a degenerate or
  // fully out-of-range request still describes at least one legal pixel.
  always_comb begin
    w_x0c  = clamp_col(iX0);
    w_x1c  = clamp_col(iX1);
    w_y0c  = clamp_row(iY0);
    w_y1c  = clamp_row(iY1);
    w_xmin = 11'd0;
    w_xmax = LP_MAX_COL;
    w_ymin = 10'd0;
    w_ymax = LP_MAX_ROW;
    if (iOp) begin
      w_xmin = 11'd0;
      w_xmax = LP_MAX_COL;
      w_ymin = 10'd0;
      w_ymax = LP_MAX_ROW;
    end else begin
      if (w_x0c > w_x1c) begin
        w_xmin = w_x1c;
        w_xmax = w_x0c;
      end else begin
        w_xmin = w_x0c;
        w_xmax = w_x1c;
      end
      if (w_y0c > w_y1c) begin
        w_ymin = w_y1c;
        w_ymax = w_y0c;
      end else begin
        w_ymin = w_y0c;
        w_ymax = w_y1c;
      end
    end
  end

  // End-of-line and end-of-rectangle detection for the pixel walk.
  always_comb begin
    w_last_col = (r_col == r_xmax);
    w_last_row = (r_row == r_ymax);
  end

  // Main FSM: clear after reset, wait for a command, walk the rectangle,
  // pulse done. All outputs are registered here.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= INIT_CLEAR;
      r_col   <= 11'd0;
      r_row   <= 10'd0;
      r_xmin  <= 11'd0;
      r_xmax  <= LP_MAX_COL;
      r_ymin  <= 10'd0;
      r_ymax  <= LP_MAX_ROW;
      r_color <= 3'b000;
      r_we    <= 1'b0;
      r_wcol  <= 11'd0;
      r_wrow  <= 10'd0;
      r_rgb   <= 3'b000;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        // The power-up clear uses the full-frame bounds and black colour
        // loaded by reset, so it shares the fill walk.
        INIT_CLEAR, FILL: begin
          r_we    <= 1'b1;
          r_wcol  <= r_col;
          r_wrow  <= r_row;
          r_rgb   <= r_color;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
          if (w_last_col) begin
            r_col <= r_xmin;
            if (w_last_row) begin
              r_row   <= r_ymin;
              r_state <= DONE;
            end else begin
              r_row <= r_row + 10'd1;
            end
          end else begin
            r_col <= r_col + 11'd1;
          end
        end
        DONE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        // Ready is raised one cycle after the done pulse; a request seen
        // while ready is still low is simply not taken.
        IDLE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
          if (r_ready && iCmdValid) begin
            r_xmin  <= w_xmin;
            r_xmax  <= w_xmax;
            r_ymin  <= w_ymin;
            r_ymax  <= w_ymax;
            r_col   <= w_xmin;
            r_row   <= w_ymin;
            r_color <= iColor;
            r_ready <= 1'b0;
            r_state <= FILL;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT_CLEAR;
          r_col   <= 11'd0;
          r_row   <= 10'd0;
          r_xmin  <= 11'd0;
          r_xmax  <= LP_MAX_COL;
          r_ymin  <= 10'd0;
          r_ymax  <= LP_MAX_ROW;
          r_color <= 3'b000;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign oCmdReady    = r_ready;
  assign oWriteEnable = r_we;
  assign oWriteCol    = r_wcol;
  assign oWriteRow    = r_wrow;
  assign oRGB         = r_rgb;
  assign oDone        = r_done;

endmodule

// File: doc/vga_ram_painter.md
VGA_RAM_PAINTER -- requirements
Module: vga_ram_painter

Interface
REQ-001 The block SHALL have parameter MAX_COL, default 639, meaning the last writable pixel column.
REQ-002 The block SHALL have parameter MAX_ROW, default 479, meaning the last writable pixel row.
REQ-003 The block SHALL have port Clock, input, 1 bit, the clock shared with the video RAM write port.
REQ-004 The block SHALL have port Reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL have port iCmdValid, input, 1 bit, the command request.
REQ-006 The block SHALL have port oCmdReady, output, 1 bit, meaning a command can be accepted.
REQ-007 The block SHALL have port iOp, input, 1 bit: 0 = fill rectangle, 1 = fill whole frame.
REQ-008 The block SHALL have ports iX0 and iX1, input, 11 bits each, the rectangle corner columns.
REQ-009 The block SHALL have ports iY0 and iY1, input, 10 bits each, the rectangle corner rows.
REQ-010 The block SHALL have port iColor, input, 3 bits, the RGB value to write.
REQ-011 The block SHALL have port oWriteEnable, output, 1 bit, the RAM write strobe.
REQ-012 The block SHALL have port oWriteCol, output, 11 bits, the RAM write column.
REQ-013 The block SHALL have port oWriteRow, output, 10 bits, the RAM write row.
REQ-014 The block SHALL have port oRGB, output, 3 bits, the RAM write data.
REQ-015 The block SHALL have port oDone, output, 1 bit, a one-cycle pulse marking command completion.

Function
REQ-016 The state machine SHALL have exactly the states INIT_CLEAR, IDLE, FILL and DONE.
REQ-017 After Reset is released, the block SHALL enter INIT_CLEAR and write 3'b000 to every pixel (0..MAX_COL, 0..MAX_ROW) with oCmdReady=0.
REQ-018 In INIT_CLEAR, the first write SHALL occur in the first Clock edge after Reset is released.
REQ-019 The block SHALL accept a command on a rising Clock edge with iCmdValid=1 and oCmdReady=1; oCmdReady SHALL be 1 only in IDLE.
REQ-020 On acceptance, the block SHALL latch iOp, the coordinates and iColor; input changes after acceptance SHALL have no effect.
REQ-021 For iOp=1, the block SHALL use the bounds (0,0)-(MAX_COL,MAX_ROW) and ignore the coordinate inputs.
REQ-022 For iOp=0, the block SHALL first clamp each coordinate to MAX_COL or MAX_ROW, then swap each pair if X0>X1 or Y0>Y1, so at least 1 pixel is always written.
REQ-023 In FILL, the block SHALL write one pixel per Clock with oWriteEnable=1, in raster order (column fastest, then row), starting at (xmin,ymin) in the cycle after acceptance.
REQ-024 A rectangle of W×H pixels SHALL take exactly W×H consecutive write cycles, with no gaps.
REQ-025 After the last pixel (xmax,ymax), the block SHALL enter DONE for 1 cycle with oDone=1 and oWriteEnable=0, then return to IDLE.
REQ-026 The latency from accept to oDone SHALL be W×H+1 cycles.
REQ-027 INIT_CLEAR completion SHALL also pulse oDone for 1 cycle.
REQ-028 When oWriteEnable=0, oWriteCol, oWriteRow and oRGB SHALL hold their last values.
REQ-029 A command SHALL be accepted on the cycle after DONE at the earliest; iCmdValid while not ready SHALL be ignored and not queued.
REQ-030 Column and row counters SHALL never exceed MAX_COL or MAX_ROW; no write outside the bounds SHALL ever occur.

Reset
REQ-031 Reset=1 SHALL immediately force oWriteEnable=0, oDone=0, oCmdReady=0, oWriteCol=0, oWriteRow=0 and oRGB=0, and put the state machine in INIT_CLEAR with the counters at 0.
REQ-032 A Reset during FILL or INIT_CLEAR SHALL abort the operation without completing it; after release, a full INIT_CLEAR SHALL run again.

Verification
REQ-033 The bench SHALL cover this scenario: release Reset with MAX_COL=7, MAX_ROW=3 -> 32 writes of 3'b000 in raster order, then oDone pulse, then oCmdReady=1.
REQ-034 The bench SHALL cover this scenario: iOp=0, (2,1)-(4,2), color 3'b101 -> 6 consecutive writes at (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), and oDone 7 cycles after accept.
REQ-035 The bench SHALL cover this scenario: iOp=0, X0=5, X1=1, Y0=Y1=0 -> swapped bounds, writes at columns 1..5 in row 0.
REQ-036 The bench SHALL cover this scenario: iOp=0, X0=X1=900, Y0=Y1=700 with default parameters -> a single write at (639,479).
REQ-037 The bench SHALL cover this scenario: iCmdValid held high during FILL -> no acceptance until IDLE; exactly one extra command executes per ready cycle.
REQ-038 The bench SHALL cover this scenario: Reset asserted mid-FILL -> outputs go to 0 in the same cycle; after release, INIT_CLEAR restarts at (0,0).
